simd_alu_writeback: RTL and testbench

- Writeback stage directly downstream of the 4-lane SIMD ALU array (4 x 32-bit lanes, shared select).
- Captures the 128-bit lane-concatenated result, the 4 per-lane nop flags and the destination register into a small skid FIFO.
- Drives a valid/ready write port into the vector register file with per-lane write enables; lanes flagged nop are never written.
- Decouples the ALU issue path from register-file back-pressure.

---
 rtl/simd_alu_writeback.sv | 101 ++++++++++
 tb/tb_simd_alu_writeback.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_writeback.sv
// Writeback stage behind the SIMD ALU array: skid FIFO of lane results
// feeding the vector register file write port with per-lane enables.
module simd_alu_writeback #(
    parameter int DATA_W     = 128,
    parameter int LANES      = 4,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_result,
    input  logic [LANES-1:0]             in_nop_flags,
    input  logic [REG_ADDR_W-1:0]        in_rd,
    input  logic                         in_wr_en,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [REG_ADDR_W-1:0]        wb_addr,
    output logic [DATA_W-1:0]            wb_data,
    output logic [LANES-1:0]             wb_lane_we,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_W-1:0]             retire_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [LANES-1:0]      we;
    } wb_entry_t;

    generate
        if (DATA_W != LANES*32) begin : g_bad_width
            $error("DATA_W must equal LANES*32");
        end
    endgenerate

    wb_entry_t        mem [DEPTH];
    wb_entry_t        head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LANES-1:0] lane_we;
    logic             accept;
    logic             push;
    logic             drop;
    logic             pop;

    assign in_ready = (count < CW'(DEPTH));
    assign wb_valid = (count != '0);

    assign lane_we = ~in_nop_flags & {LANES{in_wr_en}};
    assign accept  = in_valid & in_ready & ~flush;
    assign push    = accept & (|lane_we);
    // Nothing to write: the instruction retires straight from the accept.
    assign drop    = accept & ~(|lane_we);
    assign pop     = wb_valid & wb_ready;

    always_comb begin
        head       = mem[rd_ptr];
        wb_addr    = '0;
        wb_data    = '0;
        wb_lane_we = '0;
        if (wb_valid) begin
            wb_addr    = head.addr;
            wb_data    = head.data;
            wb_lane_we = head.we;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: in_rd, data: in_result, we: lane_we};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            retire_cnt <= '0;
        end else begin
            retire_cnt <= retire_cnt + CNT_W'(pop) + CNT_W'(drop);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_simd_alu_writeback.sv
// Directed bench for simd_alu_writeback: masking, back-pressure,
// streaming, flush, async reset and retire counter wrap.
module tb_simd_alu_writeback;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_result;
    logic [3:0]   in_nop_flags;
    logic [3:0]   in_rd;
    logic         in_wr_en;
    logic         wb_valid;
    logic         wb_ready;
    logic [3:0]   wb_addr;
    logic [127:0] wb_data;
    logic [3:0]   wb_lane_we;
    logic [1:0]   count;
    logic [15:0]  retire_cnt;

    int n_cmp = 0;
    int n_err = 0;

    simd_alu_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_nop_flags (in_nop_flags),
        .in_rd        (in_rd),
        .in_wr_en     (in_wr_en),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_lane_we   (wb_lane_we),
        .count        (count),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] r,
                         input logic [3:0] nop, input logic [3:0] rd,
                         input logic we);
        in_valid     = v;
        in_result    = r;
        in_nop_flags = nop;
        in_rd        = rd;
        in_wr_en     = we;
    endtask

    localparam logic [127:0] R1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] R2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] DA = 128'hA;
    localparam logic [127:0] DB = 128'hB;
    localparam logic [127:0] DC = 128'hC;

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, '0, 4'h0, 4'h0, 1'b0);
        #12;
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_wb_valid", 128'(wb_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_retire", 128'(retire_cnt), 128'd0);
        chk("rst_wb_data", wb_data, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single write
        wb_ready = 1'b1;
        drive(1'b1, R1, 4'b0000, 4'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("single_valid", 128'(wb_valid), 128'd1);
        chk("single_addr", 128'(wb_addr), 128'd5);
        chk("single_data", wb_data, R1);
        chk("single_we", 128'(wb_lane_we), 128'hF);
        chk("single_retire0", 128'(retire_cnt), 128'd0);
        tick();
        chk("single_retire1", 128'(retire_cnt), 128'd1);
        chk("single_empty", 128'(wb_valid), 128'd0);
        chk("single_zero_data", wb_data, 128'd0);

        // lane masking
        drive(1'b1, R2, 4'b0101, 4'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("mask_we", 128'(wb_lane_we), 128'hA);
        chk("mask_addr", 128'(wb_addr), 128'd3);
        chk("mask_data", wb_data, R2);
        tick();
        chk("mask_retire", 128'(retire_cnt), 128'd2);
        drive(1'b1, R1, 4'b1111, 4'd9, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("allnop_retire", 128'(retire_cnt), 128'd3);
        chk("allnop_valid", 128'(wb_valid), 128'd0);
        drive(1'b1, R1, 4'b0000, 4'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("nowr_retire", 128'(retire_cnt), 128'd4);
        chk("nowr_count", 128'(count), 128'd0);

        // back-pressure
        wb_ready = 1'b0;
        drive(1'b1, DA, 4'b0000, 4'd1, 1'b1);
        tick();
        drive(1'b1, DB, 4'b0000, 4'd2, 1'b1);
        tick();
        chk("bp_count", 128'(count), 128'd2);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        chk("bp_head_addr", 128'(wb_addr), 128'd1);
        drive(1'b1, DC, 4'b0000, 4'd7, 1'b1);
        tick();
        chk("bp_hold_count", 128'(count), 128'd2);
        chk("bp_hold_data", wb_data, DA);
        chk("bp_hold_addr", 128'(wb_addr), 128'd1);
        wb_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_pop1_addr", 128'(wb_addr), 128'd2);
        chk("bp_pop1_data", wb_data, DB);
        chk("bp_pop1_count", 128'(count), 128'd1);
        chk("bp_pop1_ready", 128'(in_ready), 128'd1);
        tick();
        chk("bp_pop2_count", 128'(count), 128'd0);
        chk("bp_retire", 128'(retire_cnt), 128'd6);

        // streaming
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 128'(i) * 128'h1111, 4'b0000, 4'(i), 1'b1);
            tick();
            chk("stream_addr", 128'(wb_addr), 128'(i));
            chk("stream_data", wb_data, 128'(i) * 128'h1111);
            chk("stream_count", 128'(count), 128'd1);
            chk("stream_retire", 128'(retire_cnt), 128'(6 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_retire", 128'(retire_cnt), 128'd14);
        chk("stream_end_count", 128'(count), 128'd0);

        // flush with full FIFO
        wb_ready = 1'b0;
        drive(1'b1, DA, 4'b0000, 4'd4, 1'b1);
        tick();
        drive(1'b1, DB, 4'b0000, 4'd6, 1'b1);
        tick();
        chk("fl_pre_count", 128'(count), 128'd2);
        wb_ready = 1'b1;
        flush    = 1'b1;
        drive(1'b1, DC, 4'b0000, 4'd8, 1'b1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_retire", 128'(retire_cnt), 128'd15);
        chk("fl_count", 128'(count), 128'd0);
        chk("fl_valid", 128'(wb_valid), 128'd0);
        chk("fl_in_ready", 128'(in_ready), 128'd1);
        flush = 1'b1;
        drive(1'b1, DC, 4'b0000, 4'd8, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_drop_ignored", 128'(retire_cnt), 128'd15);
        drive(1'b1, DC, 4'b0000, 4'd8, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("fl_after_ptr", wb_data, DC);
        chk("fl_after_addr", 128'(wb_addr), 128'd8);
        tick();

        // async reset mid-stream
        wb_ready = 1'b0;
        drive(1'b1, DA, 4'b0000, 4'd1, 1'b1);
        tick();
        drive(1'b1, DB, 4'b0000, 4'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("ar_pre_count", 128'(count), 128'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 128'(count), 128'd0);
        chk("ar_valid", 128'(wb_valid), 128'd0);
        chk("ar_data", wb_data, 128'd0);
        chk("ar_we", 128'(wb_lane_we), 128'd0);
        chk("ar_retire", 128'(retire_cnt), 128'd0);
        chk("ar_in_ready", 128'(in_ready), 128'd1);
        tick();
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        tick();
        chk("ar_post_valid", 128'(wb_valid), 128'd0);
        chk("ar_post_retire", 128'(retire_cnt), 128'd0);

        // retire counter wrap via dropped accepts
        wb_ready = 1'b0;
        drive(1'b1, DA, 4'b0000, 4'd0, 1'b0);
        for (int i = 0; i < 65535; i++) tick();
        chk("wrap_pre", 128'(retire_cnt), 128'hFFFF);
        tick();
        in_valid = 1'b0;
        chk("wrap_post", 128'(retire_cnt), 128'h0);
        chk("wrap_count", 128'(count), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
